pixels_lost_seq: RTL and testbench



---
 rtl/pixels_lost_pkg.sv | 23 ++
 rtl/lost_divider.sv | 56 +++++
 rtl/pixels_lost_seq.sv | 169 ++++++++++++++++
 tb/tb_pixels_lost_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixels_lost_pkg.sv
// Shared types and constants for the sequential pixels-lost estimator.
package pixels_lost_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StArea,
    StDiv,
    StDone
  } state_e;

  localparam int unsigned MAC_CYCLES = 8;
  localparam int unsigned DIV_STEPS  = 7;

  function automatic int unsigned frame_area(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  function automatic int unsigned frame_area_width(input int unsigned w, input int unsigned h);
    return $clog2(w * h + 1);
  endfunction

endpackage

// File: rtl/lost_divider.sv
// Restoring divider by a constant: load captures the dividend, each step resolves one
// quotient bit from MSB down.
module lost_divider #(
  parameter int unsigned Divisor   = 307200,
  parameter int unsigned DividendW = 26,
  parameter int unsigned QuotW     = 7
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [DividendW-1:0] dividend_i,
  output logic [QuotW-1:0]     quotient_o
);

  localparam int unsigned KW = (QuotW > 1) ? $clog2(QuotW) : 1;

  logic [DividendW-1:0] rem_q, rem_d;
  logic [QuotW-1:0]     quo_q, quo_d;
  logic [KW-1:0]        k_q, k_d;
  logic [DividendW-1:0] div_shift;

  assign div_shift = DividendW'(Divisor) << k_q;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    k_d   = k_q;
    if (load_i) begin
      rem_d = dividend_i;
      quo_d = '0;
      k_d   = KW'(QuotW - 1);
    end else if (step_i) begin
      if (rem_q >= div_shift) begin
        rem_d        = rem_q - div_shift;
        quo_d[k_q]   = 1'b1;
      end
      k_d = k_q - KW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= '0;
      quo_q <= '0;
      k_q   <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      k_q   <= k_d;
    end
  end

  assign quotient_o = quo_q;

endmodule

// File: rtl/pixels_lost_seq.sv
// Shoelace area of the keystone quadrilateral on one shared multiplier, then the
// percentage of the frame left uncovered via a restoring divider. Fixed 17-edge latency.
module pixels_lost_seq
  import pixels_lost_pkg::*;
#(
  parameter int unsigned XW      = 10,
  parameter int unsigned YW      = 9,
  parameter int unsigned FRAME_W = 640,
  parameter int unsigned FRAME_H = 480,
  parameter int unsigned PCT_W   = DIV_STEPS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [XW-1:0]    x1,
  input  logic [YW-1:0]    y1,
  input  logic [XW-1:0]    x2,
  input  logic [YW-1:0]    y2,
  input  logic [XW-1:0]    x3,
  input  logic [YW-1:0]    y3,
  input  logic [XW-1:0]    x4,
  input  logic [YW-1:0]    y4,
  output logic             busy,
  output logic             done,
  output logic [PCT_W-1:0] percent_lost,
  output logic [XW+YW-1:0] area
);

  localparam int unsigned ProdW  = XW + YW;
  localparam int unsigned AccW   = XW + YW + 3;
  localparam int unsigned Fa     = frame_area(FRAME_W, FRAME_H);
  localparam int unsigned FaW    = frame_area_width(FRAME_W, FRAME_H);
  localparam int unsigned DivW   = FaW + PCT_W;
  localparam int unsigned CmpW   = (AccW > FaW) ? AccW : FaW;
  localparam int unsigned CntMax = (MAC_CYCLES > PCT_W) ? MAC_CYCLES : PCT_W;
  localparam int unsigned CntW   = $clog2(CntMax);

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [3:0][XW-1:0]        x_q, x_d;
  logic [3:0][YW-1:0]        y_q, y_d;
  logic signed [AccW-1:0]    acc_q, acc_d;
  logic [AccW-1:0]           a_q, a_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [PCT_W-1:0]          pct_q, pct_d;
  logic [ProdW-1:0]          area_q, area_d;

  logic [1:0]                idx, nxt;
  logic [XW-1:0]             mul_a;
  logic [YW-1:0]             mul_b;
  logic [ProdW-1:0]          prod;
  logic signed [AccW-1:0]    prod_s;
  logic [AccW-1:0]           acc_abs, area_mag;
  logic [CmpW-1:0]           a_cmp, lost;
  logic [DivW-1:0]           dividend;
  logic                      div_load, div_step;
  logic [PCT_W-1:0]          quotient;

  // Steps 0..3 add x(i)*y(i+1); steps 4..7 subtract x(i+1)*y(i).
  assign idx    = cnt_q[1:0];
  assign nxt    = idx + 2'd1;
  assign mul_a  = cnt_q[2] ? x_q[nxt] : x_q[idx];
  assign mul_b  = cnt_q[2] ? y_q[idx] : y_q[nxt];
  assign prod   = ProdW'(mul_a) * ProdW'(mul_b);
  assign prod_s = signed'(AccW'(prod));

  assign acc_abs  = acc_q[AccW-1] ? -acc_q : acc_q;
  assign area_mag = acc_abs >> 1;
  assign a_cmp    = CmpW'(area_mag);
  assign lost     = (a_cmp < CmpW'(Fa)) ? (CmpW'(Fa) - a_cmp) : '0;
  assign dividend = DivW'(lost) * DivW'(100);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    a_d      = a_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pct_d    = pct_q;
    area_d   = area_q;
    div_load = 1'b0;
    div_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_d = start;
        if (start) begin
          x_d     = {x4, x3, x2, x1};
          y_d     = {y4, y3, y2, y1};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = cnt_q[2] ? (acc_q - prod_s) : (acc_q + prod_s);
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(MAC_CYCLES - 1)) state_d = StArea;
      end
      StArea: begin
        a_d      = area_mag;
        div_load = 1'b1;
        cnt_d    = CntW'(PCT_W - 1);
        state_d  = StDiv;
      end
      StDiv: begin
        div_step = 1'b1;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == '0) state_d = StDone;
      end
      StDone: begin
        // Outputs and done register on leaving DONE; busy covers the done cycle.
        done_d  = 1'b1;
        pct_d   = quotient;
        area_d  = (|a_q[AccW-1:ProdW]) ? '1 : a_q[ProdW-1:0];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pct_q   <= '0;
      area_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pct_q   <= pct_d;
      area_q  <= area_d;
    end
  end

  lost_divider #(
    .Divisor  (Fa),
    .DividendW(DivW),
    .QuotW    (PCT_W)
  ) u_lost_divider (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_i    (div_load),
    .step_i    (div_step),
    .dividend_i(dividend),
    .quotient_o(quotient)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign percent_lost = pct_q;
  assign area         = area_q;

endmodule

// File: tb/tb_pixels_lost_seq.sv
// Scoreboard bench for pixels_lost_seq: expectations pushed at accept, checked at done.
module tb_pixels_lost_seq;

  localparam int XW      = 10;
  localparam int YW      = 9;
  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;
  localparam int PCT_W   = 7;
  localparam int LAT     = 17;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic             start   = 1'b0;
  logic [XW-1:0]    x1 = '0, x2 = '0, x3 = '0, x4 = '0;
  logic [YW-1:0]    y1 = '0, y2 = '0, y3 = '0, y4 = '0;
  logic             busy, done;
  logic [PCT_W-1:0] percent_lost;
  logic [XW+YW-1:0] area;

  pixels_lost_seq #(
    .XW     (XW),
    .YW     (YW),
    .FRAME_W(FRAME_W),
    .FRAME_H(FRAME_H),
    .PCT_W  (PCT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .x1          (x1),
    .y1          (y1),
    .x2          (x2),
    .y2          (y2),
    .x3          (x3),
    .y3          (y3),
    .x4          (x4),
    .y4          (y4),
    .busy        (busy),
    .done        (done),
    .percent_lost(percent_lost),
    .area        (area)
  );

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt++;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    longint area;
    longint pct;
    int     edge_no;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int xs[4], input int ys[4], input int acc_edge);
    longint s = 0;
    longint a, fa, lost;
    exp_t   e;
    for (int i = 0; i < 4; i++)
      s += longint'(xs[i]) * ys[(i + 1) % 4] - longint'(xs[(i + 1) % 4]) * ys[i];
    a    = ((s < 0) ? -s : s) / 2;
    fa   = longint'(FRAME_W) * FRAME_H;
    lost = (a < fa) ? fa - a : 0;
    e.pct     = lost * 100 / fa;
    e.area    = (a > (longint'(1) << (XW + YW)) - 1) ? (longint'(1) << (XW + YW)) - 1 : a;
    e.edge_no = acc_edge + LAT;
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("area", area, e.area);
        check_eq("percent_lost", percent_lost, e.pct);
        check_eq("done_edge", edge_cnt, e.edge_no);
      end
    end
  end

  task automatic set_corners(input int xs[4], input int ys[4]);
    x1 = XW'(xs[0]); x2 = XW'(xs[1]); x3 = XW'(xs[2]); x4 = XW'(xs[3]);
    y1 = YW'(ys[0]); y2 = YW'(ys[1]); y3 = YW'(ys[2]); y4 = YW'(ys[3]);
  endtask

  task automatic scramble();
    x1 = XW'($urandom); x2 = XW'($urandom); x3 = XW'($urandom); x4 = XW'($urandom);
    y1 = YW'($urandom); y2 = YW'($urandom); y3 = YW'($urandom); y4 = YW'($urandom);
  endtask

  // Called at a negedge; the next posedge is the accept edge.
  task automatic issue(input int xs[4], input int ys[4]);
    set_corners(xs, ys);
    start = 1'b1;
    sb.push_back(model(xs, ys, edge_cnt + 1));
  endtask

  task automatic wait_until(input int e);
    while (edge_cnt < e) @(negedge clock);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run(input int xs[4], input int ys[4]);
    @(negedge clock);
    issue(xs, ys);
    @(negedge clock);
    start = 1'b0;
    scramble();
    check_eq("busy_after_accept", busy, 1);
    wait_drain();
    @(negedge clock);
    check_eq("busy_after_done", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sqx[4] = '{80, 80, 160, 160};
    int sqy[4] = '{80, 160, 160, 80};
    int ffx[4] = '{0, 0, 639, 639};
    int ffy[4] = '{0, 479, 479, 0};
    int rvx[4] = '{639, 639, 0, 0};
    int rvy[4] = '{0, 479, 479, 0};
    int dgx[4] = '{100, 100, 100, 100};
    int dgy[4] = '{100, 100, 100, 100};
    int ovx[4] = '{0, 0, 1023, 1023};
    int ovy[4] = '{0, 511, 511, 0};
    int rcx[4] = '{100, 100, 400, 400};
    int rcy[4] = '{50, 300, 300, 50};
    int rx[4];
    int ry[4];
    int a0;

    @(negedge clock);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pct", percent_lost, 0);
    check_eq("rst_area", area, 0);
    @(negedge clock);
    reset_n = 1'b1;

    run(sqx, sqy);
    run(ffx, ffy);
    run(rvx, rvy);
    run(dgx, dgy);
    run(ovx, ovy);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        rx[i] = int'($urandom_range(0, 1023));
        ry[i] = int'($urandom_range(0, 511));
      end
      run(rx, ry);
    end

    // Start pulses while busy are ignored; a start at edge 18 is accepted back-to-back.
    @(negedge clock);
    issue(sqx, sqy);
    a0 = edge_cnt + 1;
    @(negedge clock);
    start = 1'b0;
    scramble();
    wait_until(a0 + 2);
    set_corners(dgx, dgy);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_until(a0 + 9);
    set_corners(ovx, ovy);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    scramble();
    wait_until(a0 + 17);
    issue(rcx, rcy);
    @(negedge clock);
    start = 1'b0;
    scramble();
    check_eq("b2b_busy", busy, 1);
    check_eq("b2b_done_low", done, 0);
    wait_drain();
    @(negedge clock);

    // Asynchronous reset mid-run discards the result.
    issue(sqx, sqy);
    a0 = edge_cnt + 1;
    @(negedge clock);
    start = 1'b0;
    scramble();
    wait_until(a0 + 8);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_pct", percent_lost, 0);
    check_eq("midrst_area", area, 0);
    sb.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (25) @(negedge clock);
    check_eq("post_rst_idle_busy", busy, 0);

    run(sqx, sqy);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
